mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data access sequencer for a single-port memory; data has priority with a fetch starvation guard.
// Define MEM_ARBITER_BOUNDS_CHECK_EN to suppress and flag data accesses at or above MEMADDRS.
module mem_arbiter #(
    parameter int BITS         = 16,
    parameter int MEMADDRS     = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_i_req,
    input  logic [7:0]      i_i_addr,
    output logic            o_i_ack,
    output logic [BITS-1:0] o_i_rdata,
    input  logic            i_d_req,
    input  logic            i_d_we,
    input  logic [7:0]      i_d_addr,
    input  logic [BITS-1:0] i_d_wdata,
    output logic            o_d_ack,
    output logic [BITS-1:0] o_d_rdata,
    output logic            o_d_err,
    output logic            o_mem_rw,
    output logic [7:0]      o_mem_addr,
    output logic [BITS-1:0] o_mem_data,
    input  logic [BITS-1:0] i_mem_data,
    output logic            o_busy
);

`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [8:0] ADDR_END = 9'(MEMADDRS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t     state;
    logic       win_d;
    logic       lat_we;
    logic [3:0] starve_cnt;

    logic starved;
    logic grant_d;
    logic grant_i;
    logic oob;

    assign starved = i_i_req && (starve_cnt == LIMIT);
    assign grant_d = i_d_req && !starved;
    assign grant_i = i_i_req && !grant_d;

    // o_mem_addr doubles as the latched access address
    assign oob = BOUNDS_EN && ({1'b0, o_mem_addr} >= ADDR_END);

    assign o_mem_rw = (state == ACCESS) && lat_we && !oob && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            win_d      <= 1'b0;
            lat_we     <= 1'b0;
            starve_cnt <= '0;
            o_i_ack    <= 1'b0;
            o_d_ack    <= 1'b0;
            o_d_err    <= 1'b0;
            o_busy     <= 1'b0;
            o_i_rdata  <= '0;
            o_d_rdata  <= '0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        grant_d: begin
                            state      <= ACCESS;
                            o_busy     <= 1'b1;
                            win_d      <= 1'b1;
                            lat_we     <= i_d_we;
                            o_mem_addr <= i_d_addr;
                            o_mem_data <= i_d_wdata;
                            if (!i_i_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                        grant_i: begin
                            state      <= ACCESS;
                            o_busy     <= 1'b1;
                            win_d      <= 1'b0;
                            lat_we     <= 1'b0;
                            o_mem_addr <= i_i_addr;
                            starve_cnt <= '0;
                        end
                        default: ;
                    endcase
                end
                ACCESS: begin
                    state <= ACK;
                    if (win_d) begin
                        o_d_ack <= 1'b1;
                        o_d_err <= oob;
                        if (oob)
                            o_d_rdata <= '0;
                        else if (!lat_we)
                            o_d_rdata <= i_mem_data;
                    end else begin
                        o_i_ack   <= 1'b1;
                        o_i_rdata <= oob ? '0 : i_mem_data;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_i_ack <= 1'b0;
                    o_d_ack <= 1'b0;
                    o_d_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed stimulus for mem_arbiter against a transaction-level model.
// Honours MEM_ARBITER_BOUNDS_CHECK_EN in the expected behaviour.
module tb_mem_arbiter;

    localparam int BITS     = 16;
    localparam int MEMADDRS = 200;
    localparam int LIMIT    = 4;

`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ireq = 1'b0;
    logic [7:0]      iaddr = '0;
    logic            i_ack;
    logic [BITS-1:0] i_rdata;
    logic            dreq = 1'b0;
    logic            dwe = 1'b0;
    logic [7:0]      daddr = '0;
    logic [BITS-1:0] dwdata = '0;
    logic            d_ack;
    logic [BITS-1:0] d_rdata;
    logic            d_err;
    logic            mem_rw;
    logic [7:0]      mem_addr;
    logic [BITS-1:0] mem_wdata;
    logic [BITS-1:0] mem_rdata;
    logic            busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .BITS(BITS),
        .MEMADDRS(MEMADDRS),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_i_req(ireq),
        .i_i_addr(iaddr),
        .o_i_ack(i_ack),
        .o_i_rdata(i_rdata),
        .i_d_req(dreq),
        .i_d_we(dwe),
        .i_d_addr(daddr),
        .i_d_wdata(dwdata),
        .o_d_ack(d_ack),
        .o_d_rdata(d_rdata),
        .o_d_err(d_err),
        .o_mem_rw(mem_rw),
        .o_mem_addr(mem_addr),
        .o_mem_data(mem_wdata),
        .i_mem_data(mem_rdata),
        .o_busy(busy)
    );

    function automatic logic [BITS-1:0] init_word(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Memory: preset contents until a word is written
    logic [BITS-1:0] mem [256];
    bit              wr  [256];

    assign mem_rdata = wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);

    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mode  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Transaction-level reference: a grant at edge g owns the memory
    // in cycle g, acknowledges in cycle g+1, and frees it at edge g+2.
    logic [BITS-1:0] ref_mem [256];
    bit              act = 1'b0;
    int              g = 0;
    bit              pd = 1'b0;
    logic [7:0]      maddr = '0;
    bit              mwe = 1'b0;
    logic [BITS-1:0] mwd = '0;
    int              starve = 0;
    logic [BITS-1:0] e_ird = '0;
    logic [BITS-1:0] e_drd = '0;
    bit              e_oob = 1'b0;
    bit              glog[$];

    task automatic model_step();
        bit was;
        cyc++;
        if (rst) begin
            act    = 1'b0;
            starve = 0;
            e_ird  = '0;
            e_drd  = '0;
        end else begin
            was = act;
            if (act && cyc == g + 1) begin
                e_oob = BCHK && (int'(maddr) >= MEMADDRS);
                if (pd) begin
                    if (e_oob)
                        e_drd = '0;
                    else if (mwe)
                        ref_mem[maddr] = mwd;
                    else
                        e_drd = ref_mem[maddr];
                end else begin
                    e_ird = e_oob ? '0 : ref_mem[maddr];
                end
            end
            if (act && cyc == g + 2)
                act = 1'b0;
            if (!was && (ireq || dreq)) begin
                act = 1'b1;
                g   = cyc;
                if (dreq && !(ireq && starve == LIMIT)) begin
                    pd     = 1'b1;
                    maddr  = daddr;
                    mwe    = dwe;
                    mwd    = dwdata;
                    starve = ireq ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                end else begin
                    pd     = 1'b0;
                    maddr  = iaddr;
                    mwe    = 1'b0;
                    starve = 0;
                end
                glog.push_back(pd);
            end
        end
    endtask

    function automatic logic [7:0] rand_addr();
        if ($urandom % 4 == 0)
            return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, 15));
    endfunction

    task automatic drive();
        iaddr  = rand_addr();
        daddr  = rand_addr();
        dwe    = 1'($urandom);
        dwdata = 16'($urandom);
        case (mode)
            0: begin rst = 1'b1; ireq = 1'b0; dreq = 1'b0; end
            1: begin rst = 1'b0; ireq = 1'b0; dreq = 1'b0; end
            2: begin rst = 1'b0; ireq = 1'b1; dreq = 1'b1; end
            default: begin
                rst = ($urandom % 50 == 0);
                if (ireq && i_ack)
                    ireq = 1'b0;
                else if (!ireq)
                    ireq = ($urandom % 3 == 0);
                if (dreq && d_ack)
                    dreq = 1'b0;
                else if (!dreq)
                    dreq = ($urandom % 2 == 0);
            end
        endcase
    endtask

    task automatic check_outputs();
        bit in_acc;
        bit in_ack;
        in_acc = act && (cyc == g);
        in_ack = act && (cyc == g + 1);
        chk("busy", busy, act);
        chk("i_ack", i_ack, in_ack && !pd);
        chk("d_ack", d_ack, in_ack && pd);
        chk("d_err", d_err, in_ack && pd && e_oob);
        chk("i_rdata", i_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        chk("mem_rw", mem_rw,
            in_acc && mwe && !rst && !(BCHK && int'(maddr) >= MEMADDRS));
        if (in_acc)
            chk("mem_addr", mem_addr, maddr);
        if (in_acc && mwe)
            chk("mem_data", mem_wdata, mwd);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            drive();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        int bad_words;
        for (int a = 0; a < 256; a++)
            ref_mem[a] = init_word(8'(a));

        mode = 0;
        run(2);
        mode = 1;
        run(6);

        mode = 0;
        run(1);
        glog.delete();
        mode = 2;
        run(35);
        chk("grant_count", 32'(glog.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < glog.size(); k++)
            chk("grant_order", 32'(glog[k]), 32'((k % (LIMIT + 1)) != LIMIT));

        mode = 3;
        run(3000);
        mode = 1;
        run(6);

        bad_words = 0;
        for (int a = 0; a < 256; a++)
            if ((wr[a] ? mem[a] : init_word(8'(a))) !== ref_mem[a])
                bad_words++;
        chk("mem_contents", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
